// File: rtl/ravenna_spi_master.sv
// rtl/ravenna_spi_master.sv - byte-wide mode-0 SPI master with config/data registers and level IRQ
// A write to the data register shifts one byte MSB first; the RX byte and irq_pend land on the last SCK fall.
module ravenna_spi_master #(
  parameter logic [7:0] PRESC_RESET = 8'd2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        reg_cfg_we,
  input  logic [10:0] reg_cfg_di,
  output logic [10:0] reg_cfg_do,
  input  logic        reg_dat_we,
  input  logic        reg_dat_re,
  input  logic [7:0]  reg_dat_di,
  output logic [7:0]  reg_dat_do,
  output logic        reg_dat_wait,
  output logic        irq_out,
  output logic        spi_csb,
  output logic        spi_sck,
  output logic        spi_sdo,
  input  logic        spi_sdi
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0] state_q, state_d;
  logic [7:0] presc_q, presc_d;
  logic       csb_hold_q, csb_hold_d;
  logic       irq_en_q, irq_en_d;
  logic       irq_pend_q, irq_pend_d;
  logic [7:0] presc_sh_q, presc_sh_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] half_q, half_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] rx_q, rx_d;
  logic       csb_q, csb_d;
  logic       sck_q, sck_d;
  logic       sdo_q, sdo_d;

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    csb_hold_d = csb_hold_q;
    irq_en_d   = irq_en_q;
    irq_pend_d = irq_pend_q;
    presc_sh_d = presc_sh_q;
    shift_d    = shift_q;
    half_d     = half_q;
    bit_d      = bit_q;
    rx_d       = rx_q;
    csb_d      = csb_q;
    sck_d      = sck_q;
    sdo_d      = sdo_q;

    if (reg_cfg_we) begin
      presc_d    = reg_cfg_di[7:0];
      csb_hold_d = reg_cfg_di[8];
      irq_en_d   = reg_cfg_di[9];
      if (reg_cfg_di[10]) irq_pend_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (!csb_hold_q) csb_d = 1'b1;
        if (reg_dat_we) begin
          shift_d    = reg_dat_di;
          presc_sh_d = presc_q;
          state_d    = ST_LOAD;
        end
      end
      ST_LOAD: begin
        csb_d   = 1'b0;
        sdo_d   = shift_q[7];
        sck_d   = 1'b0;
        half_d  = 8'd0;
        bit_d   = 3'd0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (half_q == presc_sh_q) begin
          half_d = 8'd0;
          sck_d  = ~sck_q;
          if (!sck_q) begin
            shift_d = {shift_q[6:0], spi_sdi};
          end else if (bit_q == 3'd7) begin
            // Set is applied after the W1C above so a same-cycle clear loses.
            rx_d       = shift_q;
            irq_pend_d = 1'b1;
            csb_d      = ~csb_hold_q;
            state_d    = ST_DONE;
          end else begin
            sdo_d = shift_q[7];
            bit_d = bit_q + 3'd1;
          end
        end else begin
          half_d = half_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      presc_q    <= PRESC_RESET;
      csb_hold_q <= 1'b0;
      irq_en_q   <= 1'b0;
      irq_pend_q <= 1'b0;
      presc_sh_q <= 8'd0;
      shift_q    <= 8'd0;
      half_q     <= 8'd0;
      bit_q      <= 3'd0;
      rx_q       <= 8'd0;
      csb_q      <= 1'b1;
      sck_q      <= 1'b0;
      sdo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      csb_hold_q <= csb_hold_d;
      irq_en_q   <= irq_en_d;
      irq_pend_q <= irq_pend_d;
      presc_sh_q <= presc_sh_d;
      shift_q    <= shift_d;
      half_q     <= half_d;
      bit_q      <= bit_d;
      rx_q       <= rx_d;
      csb_q      <= csb_d;
      sck_q      <= sck_d;
      sdo_q      <= sdo_d;
    end
  end

  assign reg_cfg_do   = {irq_pend_q, irq_en_q, csb_hold_q, presc_q};
  assign reg_dat_do   = rx_q;
  assign reg_dat_wait = (reg_dat_we | reg_dat_re) & (state_q != ST_IDLE);
  assign irq_out      = irq_pend_q & irq_en_q;
  assign spi_csb      = csb_q;
  assign spi_sck      = sck_q;
  assign spi_sdo      = sdo_q;

endmodule

// File: tb/tb_ravenna_spi_master.sv
// tb/tb_ravenna_spi_master.sv - directed self-checking bench for ravenna_spi_master
module tb_ravenna_spi_master;

  logic        clk = 1'b0;
  logic        resetn;
  logic        reg_cfg_we;
  logic [10:0] reg_cfg_di;
  logic [10:0] reg_cfg_do;
  logic        reg_dat_we;
  logic        reg_dat_re;
  logic [7:0]  reg_dat_di;
  logic [7:0]  reg_dat_do;
  logic        reg_dat_wait;
  logic        irq_out;
  logic        spi_csb;
  logic        spi_sck;
  logic        spi_sdo;
  logic        spi_sdi;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] slave_byte = 8'h00;
  logic [2:0] s_cnt = 3'd0;
  logic [7:0] sdo_log = 8'h00;

  ravenna_spi_master dut (
    .clk(clk), .resetn(resetn),
    .reg_cfg_we(reg_cfg_we), .reg_cfg_di(reg_cfg_di), .reg_cfg_do(reg_cfg_do),
    .reg_dat_we(reg_dat_we), .reg_dat_re(reg_dat_re), .reg_dat_di(reg_dat_di),
    .reg_dat_do(reg_dat_do), .reg_dat_wait(reg_dat_wait), .irq_out(irq_out),
    .spi_csb(spi_csb), .spi_sck(spi_sck), .spi_sdo(spi_sdo), .spi_sdi(spi_sdi)
  );

  always #5 clk = ~clk;

  // Mode-0 slave: bit index advances after each SCK rise, restarts when deselected.
  assign spi_sdi = slave_byte[3'd7 - s_cnt];
  always @(posedge spi_sck or posedge spi_csb) begin
    if (spi_csb) s_cnt <= 3'd0;
    else         s_cnt <= s_cnt + 3'd1;
  end
  always @(posedge spi_sck) sdo_log <= {sdo_log[6:0], spi_sdo};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [10:0] v);
    reg_cfg_we = 1'b1;
    reg_cfg_di = v;
    tick();
    reg_cfg_we = 1'b0;
  endtask

  task automatic start(input logic [7:0] tx);
    reg_dat_we = 1'b1;
    reg_dat_di = tx;
    tick();
    reg_dat_we = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int hi, rises, stall;
    logic prev, csb_ok;

    resetn = 1'b0;
    reg_cfg_we = 1'b0; reg_cfg_di = '0;
    reg_dat_we = 1'b0; reg_dat_re = 1'b0; reg_dat_di = '0;
    #12;
    chk("rst_csb", spi_csb, 1);
    chk("rst_sck", spi_sck, 0);
    chk("rst_sdo", spi_sdo, 0);
    chk("rst_dat_do", reg_dat_do, 0);
    chk("rst_irq", irq_out, 0);
    chk("rst_wait", reg_dat_wait, 0);
    chk("rst_cfg_do", reg_cfg_do, 11'h002);
    resetn = 1'b1;
    tick();

    // 1: presc=0, TX 0xA5, slave 0x3C
    cfg_write(11'h000);
    slave_byte = 8'h3C;
    start(8'hA5);
    chk("t1_csb_t0", spi_csb, 1);
    tick();
    chk("t1_csb_t1", spi_csb, 0);
    chk("t1_sdo_bit7", spi_sdo, 1);
    reg_dat_re = 1'b1;
    #1;
    chk("t1_busy_read_wait", reg_dat_wait, 1);
    reg_dat_re = 1'b0;
    repeat (15) tick();
    chk("t1_pend_t16", reg_cfg_do[10], 0);
    chk("t1_sck_t16", spi_sck, 1);
    tick();
    chk("t1_rx_t17", reg_dat_do, 8'h3C);
    chk("t1_pend_t17", reg_cfg_do[10], 1);
    chk("t1_csb_t17", spi_csb, 1);
    chk("t1_sdo_order", sdo_log, 8'hA5);
    tick();
    reg_dat_re = 1'b1;
    #1;
    chk("t1_idle_read_wait", reg_dat_wait, 0);
    chk("t1_idle_read_data", reg_dat_do, 8'h3C);
    reg_dat_re = 1'b0;

    // 2: presc=3 (H=4), TX 0x81; also clears irq_pend
    cfg_write(11'h403);
    chk("t2_cfg_do", reg_cfg_do, 11'h003);
    slave_byte = 8'h99;
    start(8'h81);
    hi = 0; rises = 0; prev = 1'b0;
    repeat (64) begin
      tick();
      if (spi_sck) hi++;
      if (spi_sck && !prev) rises++;
      prev = spi_sck;
    end
    chk("t2_pend_t64", reg_cfg_do[10], 0);
    tick();
    chk("t2_pend_t65", reg_cfg_do[10], 1);
    chk("t2_rx", reg_dat_do, 8'h99);
    chk("t2_sdo_order", sdo_log, 8'h81);
    chk("t2_sck_rises", rises, 8);
    chk("t2_sck_high_clks", hi, 32);

    // 3: csb_hold back-to-back
    cfg_write(11'h500);
    slave_byte = 8'h11;
    start(8'h01);
    reg_dat_we = 1'b1;
    reg_dat_di = 8'h02;
    #1;
    chk("t3_wait_t0", reg_dat_wait, 1);
    stall = 0; csb_ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (spi_csb !== 1'b0) csb_ok = 1'b0;
      if (!reg_dat_wait) break;
      stall++;
    end
    chk("t3_stall_clks", stall, 17);
    chk("t3_rx_first", reg_dat_do, 8'h11);
    slave_byte = 8'h22;
    tick();
    reg_dat_we = 1'b0;
    if (spi_csb !== 1'b0) csb_ok = 1'b0;
    repeat (17) begin
      tick();
      if (spi_csb !== 1'b0) csb_ok = 1'b0;
    end
    chk("t3_csb_held_low", csb_ok, 1);
    chk("t3_rx_second", reg_dat_do, 8'h22);
    chk("t3_sdo_second", sdo_log, 8'h02);
    tick();
    cfg_write(11'h000);
    chk("t3_csb_after_clear", spi_csb, 0);
    tick();
    chk("t3_csb_raised", spi_csb, 1);

    // 4: interrupt enable, W1C, and set-wins on the DONE edge
    cfg_write(11'h600);
    chk("t4_irq_cleared", irq_out, 0);
    slave_byte = 8'h5A;
    start(8'h33);
    repeat (17) tick();
    chk("t4_irq_set", irq_out, 1);
    cfg_write(11'h600);
    chk("t4_irq_w1c", irq_out, 0);
    start(8'h44);
    repeat (16) tick();
    reg_cfg_we = 1'b1;
    reg_cfg_di = 11'h600;
    tick();
    reg_cfg_we = 1'b0;
    chk("t4_set_wins", irq_out, 1);
    tick();
    chk("t4_irq_stays", irq_out, 1);
    chk("t4_rx", reg_dat_do, 8'h5A);

    // 5: async reset after the 3rd SCK rise (presc=1, rise 3 at t0+11)
    cfg_write(11'h001);
    slave_byte = 8'hF0;
    start(8'h3C);
    repeat (11) tick();
    chk("t5_sck_rise3", spi_sck, 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("t5_rst_csb", spi_csb, 1);
    chk("t5_rst_sck", spi_sck, 0);
    chk("t5_rst_sdo", spi_sdo, 0);
    chk("t5_rst_dat_do", reg_dat_do, 0);
    chk("t5_rst_irq", irq_out, 0);
    chk("t5_rst_cfg", reg_cfg_do, 11'h002);
    #2;
    resetn = 1'b1;
    tick();
    slave_byte = 8'hC3;
    start(8'h5A);
    repeat (48) tick();
    chk("t5_pend_t48", reg_cfg_do[10], 0);
    tick();
    chk("t5_pend_t49", reg_cfg_do[10], 1);
    chk("t5_rx", reg_dat_do, 8'hC3);
    chk("t5_sdo_order", sdo_log, 8'h5A);
    chk("t5_csb_end", spi_csb, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
